p_layer_inv: RTL and testbench

P_LAYER_INV -- requirements
Module: p_layer_inv

---
 rtl/p_layer_inv.sv | 112 +++++++++++
 tb/tb_p_layer_inv.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/p_layer_inv.sv
// p_layer_inv: inverse of the Spongent pLayer bit permutation.
//   The forward layer moves bit j to j*B/4 mod (B-1) (bit B-1 fixed); this
//   block undoes it, sending state_in bit i to state_out bit (4*i) mod (B-1)
//   (bit B-1 fixed). One input byte is scattered into the accumulator per
//   enabled RUN cycle, so an operation takes NBYTE+2 edges with en held high.
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   start     request an operation (sampled only while idle)
//   en        advance enable (low stalls the byte walk)
//   state_in  permuted state, captured on the accepted start
//   state_out inverse-permuted state, updated only on the done edge
//   busy      high while an operation is in progress (RUN/DONE)
//   done      one-cycle pulse, state_out valid from this cycle on
module p_layer_inv #(
  parameter int B     = 264,
  parameter int NBYTE = B / 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         en,
  input  logic [B-1:0] state_in,
  output logic [B-1:0] state_out,
  output logic         busy,
  output logic         done
);

  localparam int IW = (NBYTE > 1) ? $clog2(NBYTE) : 1;
  localparam int AW = $clog2(B);
  localparam int QW = AW + 2;  // holds 4*i without truncation
  localparam logic [IW-1:0] LAST = IW'(NBYTE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [B-1:0]  r_in;
  logic [B-1:0]  r_acc;
  logic [B-1:0]  r_state_out;
  logic          r_done;
  logic [B-1:0]  w_acc_nxt;

  // Destination bit of input bit i. Called with loop constants only, so
  // this folds to wiring after unrolling.
  function automatic logic [AW-1:0] q_of(input int i);
    logic [QW-1:0] prod;
    if (i == B - 1) return AW'(B - 1);
    prod = QW'(i) << 2;
    prod = prod % QW'(B - 1);
    return prod[AW-1:0];
  endfunction

  // Scatter the byte selected by r_idx into the accumulator; every other
  // accumulator bit keeps its value.
  always_comb begin
    w_acc_nxt = r_acc;
    for (int i = 0; i < B; i++) begin
      if (IW'(i / 8) == r_idx) w_acc_nxt[q_of(i)] = r_in[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (en && r_idx == LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_in        <= '0;
      r_acc       <= '0;
      r_state_out <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_in  <= state_in;
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        S_RUN: begin
          if (en) begin
            r_acc <= w_acc_nxt;
            // Saturate on the final byte so idx never leaves 0..NBYTE-1.
            if (r_idx != LAST) r_idx <= r_idx + IW'(1);
          end
        end
        S_DONE:  r_state_out <= r_acc;
        default: ;
      endcase
    end
  end

  assign state_out = r_state_out;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_p_layer_inv.sv
module tb_p_layer_inv;
  localparam int B = 264;

  logic         clk = 1'b0;
  logic         rst, start, en;
  logic [B-1:0] state_in, state_out;
  logic         busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  p_layer_inv #(.B(B)) dut (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .state_in(state_in), .state_out(state_out), .busy(busy), .done(done)
  );

  typedef struct {
    string        name;
    logic [B-1:0] din;
    logic [B-1:0] exp;
  } vec_t;

  vec_t tbl[6];

  // Reference: destination of each bit taken straight from the spec's rule.
  function automatic logic [B-1:0] inv_ref(input logic [B-1:0] x);
    logic [B-1:0] r = '0;
    for (int i = 0; i < B; i++) r[(i == B-1) ? i : (4*i) % (B-1)] = x[i];
    return r;
  endfunction

  // Forward pLayer, used to build round-trip stimulus.
  function automatic logic [B-1:0] fwd_ref(input logic [B-1:0] x);
    logic [B-1:0] r = '0;
    for (int j = 0; j < B; j++) r[(j == B-1) ? j : (j*(B/4)) % (B-1)] = x[j];
    return r;
  endfunction

  function automatic logic [B-1:0] rand_vec();
    logic [B-1:0] r;
    for (int i = 0; i < B; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic logic [B-1:0] bitv(input int n);
    logic [B-1:0] r = '0;
    r[n] = 1'b1;
    return r;
  endfunction

  task automatic chk_v(input string name, input logic [B-1:0] act, input logic [B-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // One operation. Edge 0 is the start-sampling edge; lat is the edge after
  // which done was first seen (-1 on timeout). en is low on edges
  // stall_at..stall_at+stall_len-1. With noise set, start and state_in are
  // thrashed while busy. ok clears if busy drops or state_out moves early.
  task automatic do_op(input logic [B-1:0] din, input int stall_at, input int stall_len,
                       input bit noise, output logic [B-1:0] dout, output int lat,
                       output bit ok);
    logic [B-1:0] prev;
    @(negedge clk);
    state_in = din; start = 1'b1; en = 1'b1;
    prev = state_out;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; ok = 1'b1;
    for (int n = 1; n <= 150; n++) begin
      en = !(n >= stall_at && n < stall_at + stall_len);
      if (noise) begin start = 1'b1; state_in = rand_vec(); end
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
      if (state_out !== prev || !busy) ok = 1'b0;
    end
    start = 1'b0; en = 1'b1;
    dout = state_out;
  endtask

  logic [B-1:0] d, x, v;
  int           lat, k, seen;
  bit           ok;
  logic [B-1:0] log_q[$];

  initial begin
    tbl[0] = '{"bit1",   bitv(1),   bitv(4)};
    tbl[1] = '{"bit66",  bitv(66),  bitv(1)};
    tbl[2] = '{"bit200", bitv(200), bitv(11)};
    tbl[3] = '{"bit0",   bitv(0),   bitv(0)};
    tbl[4] = '{"bit263", bitv(263), bitv(263)};
    tbl[5] = '{"ones",   '1,        '1};

    rst = 1'b1; start = 1'b0; en = 1'b0; state_in = '1;
    #2;
    chk_v("reset state_out", state_out, '0);
    chk_i("reset busy", int'(busy), 0);
    chk_i("reset done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors.
    for (int t = 0; t < 6; t++) begin
      do_op(tbl[t].din, 0, 0, 1'b0, d, lat, ok);
      chk_v(tbl[t].name, d, tbl[t].exp);
      chk_i({tbl[t].name, " latency"}, lat, 34);
      chk_i({tbl[t].name, " busy/hold"}, int'(ok), 1);
      chk_i({tbl[t].name, " busy at done"}, int'(busy), 0);
      @(posedge clk); #1;
      chk_i({tbl[t].name, " done one cycle"}, int'(done), 0);
    end

    // Stall 5 cycles mid-RUN with start/state_in noise while busy.
    x = rand_vec();
    do_op(x, 10, 5, 1'b1, d, lat, ok);
    chk_v("stall data", d, inv_ref(x));
    chk_i("stall latency", lat, 39);
    chk_i("stall busy/hold", int'(ok), 1);
    @(posedge clk); #1;
    chk_i("stall no extra op", int'(busy), 0);

    // Reset at edge 10 of an operation.
    @(negedge clk);
    state_in = rand_vec(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk_v("abort state_out", state_out, '0);
    chk_i("abort busy", int'(busy), 0);
    chk_i("abort done", int'(done), 0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk_i("abort no done", seen, 0);
    rst = 1'b0;
    do_op(bitv(1), 0, 0, 1'b0, d, lat, ok);
    chk_v("post-reset data", d, bitv(4));
    chk_i("post-reset latency", lat, 34);

    // start held high: accepts every 35 edges, each on the value present
    // at its accept edge.
    @(negedge clk);
    start = 1'b1; en = 1'b1;
    log_q.delete();
    state_in = rand_vec(); log_q.push_back(state_in);
    k = 0;
    for (int e = 0; e < 200 && k < 3; e++) begin
      @(posedge clk); #1;
      if (done) begin
        chk_i("b2b done edge", e, 34 + 35*k);
        if (e >= 34) chk_v("b2b data", state_out, inv_ref(log_q[e-34]));
        k++;
        if (k == 3) start = 1'b0;
      end
      state_in = rand_vec(); log_q.push_back(state_in);
    end
    start = 1'b0;
    chk_i("b2b count", k, 3);
    @(posedge clk); #1;

    // Round trip through the forward layer.
    for (int r = 0; r < 1000; r++) begin
      x = rand_vec();
      v = fwd_ref(x);
      do_op(v, 0, 0, 1'b0, d, lat, ok);
      chk_v("roundtrip", d, x);
      chk_i("roundtrip latency", lat, 34);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
